// File: rtl/nand_sweep_pkg.sv
// Shared types and helpers for the NAND cell sweep sequencer and its checker.
package nand_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int unsigned VEC_N = 4;
   localparam int unsigned VEC_W = $clog2(VEC_N);

   // Golden response of a 2-input NAND.
   function automatic logic nand_ref(input logic a, input logic b);
      return ~(a & b);
   endfunction

endpackage

// File: rtl/nand_sweep_checker.sv
// Compares the cell output against the NAND reference; keeps the saturating error count and sticky fail map.
// NAND_SWEEP_XCHK_EN: when defined, X/Z on gate_out counts as a mismatch.
module nand_sweep_checker
   import nand_sweep_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [VEC_W-1:0] vec,
   input  logic             a,
   input  logic             b,
   input  logic             gate_out,
   output logic             mismatch_c,
   output logic [CNT_W-1:0] err_count,
   output logic [VEC_N-1:0] fail_vec
);

   localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [VEC_N-1:0] fail_vec_q, fail_vec_d;

   // Unknown compare results only count as failures when X-checking is enabled.
   always_comb begin
`ifdef NAND_SWEEP_XCHK_EN
      mismatch_c = (gate_out !== nand_ref(a, b));
`else
      mismatch_c = ((gate_out ^ nand_ref(a, b)) === 1'b1);
`endif
   end

   always_comb begin
      err_count_d = err_count_q;
      fail_vec_d  = fail_vec_q;
      if (clr) begin
         err_count_d = '0;
         fail_vec_d  = '0;
      end else if (en && mismatch_c) begin
         if (err_count_q != ERR_MAX) begin
            err_count_d = err_count_q + CNT_W'(1);
         end
         fail_vec_d[vec] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_count_q <= '0;
         fail_vec_q  <= '0;
      end else begin
         err_count_q <= err_count_d;
         fail_vec_q  <= fail_vec_d;
      end
   end

   assign err_count = err_count_q;
   assign fail_vec  = fail_vec_q;

endmodule

// File: rtl/nand_sweep_ctrl.sv
// Sweeps all four input vectors through a NAND cell ITERS times and reports pass/fail.
// NAND_SWEEP_XCHK_EN (in the checker) selects X/Z-aware comparison.
module nand_sweep_ctrl
   import nand_sweep_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ITERS         = 1,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             gate_a,
   output logic             gate_b,
   input  logic             gate_out,
   output logic [CNT_W-1:0] err_count,
   output logic [3:0]       fail_vec
);

   localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned ITER_W = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITERS - 1);
   localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(VEC_N - 1);

   state_e            state_q, state_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic [VEC_W-1:0]  vec_q, vec_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              gate_a_q, gate_a_d;
   logic              gate_b_q, gate_b_d;
   logic              accept_c, sample_c, mismatch_c;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      vec_d    = vec_q;
      iter_d   = iter_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      gate_a_d = gate_a_q;
      gate_b_d = gate_b_q;
      accept_c = 1'b0;
      sample_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept_c = 1'b1;
               state_d  = SETTLE;
               settle_d = SET_LOAD;
               vec_d    = '0;
               iter_d   = '0;
               busy_d   = 1'b1;
               pass_d   = 1'b0;
               gate_a_d = 1'b0;
               gate_b_d = 1'b0;
            end
         end
         SETTLE: begin
            if (settle_q == '0) begin
               state_d = SAMPLE;
            end else begin
               settle_d = settle_q - SET_W'(1);
            end
         end
         SAMPLE: begin
            sample_c = 1'b1;
            if (vec_q == VEC_LAST && iter_q == ITER_LAST) begin
               // The final sample's mismatch is not yet reflected in err_count.
               pass_d  = (err_count == '0) && !mismatch_c;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               if (vec_q == VEC_LAST) begin
                  iter_d = iter_q + ITER_W'(1);
                  vec_d  = '0;
               end else begin
                  vec_d = vec_q + VEC_W'(1);
               end
               gate_a_d = vec_d[1];
               gate_b_d = vec_d[0];
               settle_d = SET_LOAD;
               state_d  = SETTLE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         settle_q <= '0;
         vec_q    <= '0;
         iter_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         gate_a_q <= 1'b0;
         gate_b_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         vec_q    <= vec_d;
         iter_q   <= iter_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         gate_a_q <= gate_a_d;
         gate_b_q <= gate_b_d;
      end
   end

   nand_sweep_checker #(
      .CNT_W (CNT_W)
   ) u_checker (
      .clk        (clk),
      .rst        (rst),
      .clr        (accept_c),
      .en         (sample_c),
      .vec        (vec_q),
      .a          (gate_a_q),
      .b          (gate_b_q),
      .gate_out   (gate_out),
      .mismatch_c (mismatch_c),
      .err_count  (err_count),
      .fail_vec   (fail_vec)
   );

   assign busy   = busy_q;
   assign done   = done_q;
   assign pass   = pass_q;
   assign gate_a = gate_a_q;
   assign gate_b = gate_b_q;

endmodule
